// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the valid/ready data-memory port for loads and stores,
// aligns store lanes, extends load data, stalls upstream while busy and owns the MEM/WB register.
module mem_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              RegWrite_i,
   input  logic [1:0]        WriteSrc_i,
   input  logic              MemWrite_i,
   input  logic [2:0]        funct3_i,
   input  logic [31:0]       ALUout_i,
   input  logic [DATA_W-1:0] regOp2_i,
   input  logic [31:0]       ImmOp_i,
   input  logic [31:0]       pcPlus4_i,
   input  logic [4:0]        rd_i,
   output logic              stall_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [31:0]       dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   output logic [3:0]        dmem_be_o,
   input  logic              dmem_ready_i,
   input  logic              dmem_rvalid_i,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   output logic              valid_o,
   output logic              RegWrite_o,
   output logic [1:0]        WriteSrc_o,
   output logic [31:0]       ALUout_o,
   output logic [31:0]       ImmOp_o,
   output logic [31:0]       pcPlus4_o,
   output logic [4:0]        rd_o,
   output logic [DATA_W-1:0] ReadData_o,
   output logic              misalign_o
);

   localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFC :
                                       (32'((64'd1 << ADDR_W) - 64'd1) & 32'hFFFF_FFFC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state_r;

   logic is_store_s;
   logic is_load_s;
   logic mem_op_s;
   logic half_s;
   logic word_s;
   logic misaligned_s;
   logic go_s;
   logic done_s;
   logic stall_s;

   // Pick the addressed byte/half out of the returned word and extend it by funct3.
   function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        f3,
                                                     input logic [1:0]        lane,
                                                     input logic [DATA_W-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {lane, 3'b000});
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_extend = {{24{b[7]}}, b};
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b100:  load_extend = {24'h00_0000, b};
         3'b101:  load_extend = {16'h0000, h};
         default: load_extend = word;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'b000:  store_be = 4'b0001 << lane;
         3'b001:  store_be = 4'b0011 << {lane[1], 1'b0};
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f3, input logic [DATA_W-1:0] d);
      case (f3)
         3'b000:  store_data = {4{d[7:0]}};
         3'b001:  store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Decode the access; stores size on funct3 exactly, loads ignore the unsigned bit.
   always_comb begin
      is_store_s = MemWrite_i;
      is_load_s  = ~MemWrite_i & (WriteSrc_i == 2'b01);
      mem_op_s   = valid_i & (MemWrite_i | (WriteSrc_i == 2'b01));
      if (is_store_s) begin
         half_s = (funct3_i == 3'b001);
         word_s = (funct3_i != 3'b000) & (funct3_i != 3'b001);
      end else begin
         half_s = (funct3_i[1:0] == 2'b01);
         word_s = funct3_i[1];
      end
      misaligned_s = mem_op_s & ((half_s & ALUout_i[0]) | (word_s & (ALUout_i[1:0] != 2'b00)));
      go_s         = mem_op_s & ~misaligned_s;
   end

   // Completion this cycle: a store on acceptance, a load when its data returns.
   always_comb begin
      case (state_r)
         IDLE:    done_s = is_store_s & dmem_ready_i;
         REQ:     done_s = is_store_s & dmem_ready_i;
         WAIT:    done_s = dmem_rvalid_i;
         default: done_s = 1'b0;
      endcase
      stall_s = go_s & ~done_s & ~rst_i;
   end

   // Request side is combinational; upstream holds its fields steady while stalled.
   always_comb begin
      stall_o      = stall_s;
      dmem_req_o   = ~rst_i & (((state_r == IDLE) & go_s) | (state_r == REQ));
      dmem_we_o    = is_store_s;
      dmem_addr_o  = ALUout_i & ADDR_MASK;
      dmem_wdata_o = store_data(funct3_i, regOp2_i);
      if (is_store_s) begin
         dmem_be_o = store_be(funct3_i, ALUout_i[1:0]);
      end else begin
         dmem_be_o = 4'b1111;
      end
   end

   // Access FSM and MEM/WB register; a stalled cycle writes a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         valid_o    <= 1'b0;
         RegWrite_o <= 1'b0;
         WriteSrc_o <= 2'b00;
         ALUout_o   <= 32'h0000_0000;
         ImmOp_o    <= 32'h0000_0000;
         pcPlus4_o  <= 32'h0000_0000;
         rd_o       <= 5'd0;
         ReadData_o <= '0;
         misalign_o <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (go_s && !dmem_ready_i) begin
                  state_r <= REQ;
               end else if (go_s && is_load_s) begin
                  state_r <= WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               if (dmem_ready_i) begin
                  state_r <= is_load_s ? WAIT : IDLE;
               end else begin
                  state_r <= REQ;
               end
            end
            WAIT:    state_r <= dmem_rvalid_i ? IDLE : WAIT;
            default: state_r <= IDLE;
         endcase

         if (!stall_s) begin
            valid_o    <= valid_i;
            RegWrite_o <= valid_i & RegWrite_i & ~misaligned_s;
            WriteSrc_o <= WriteSrc_i;
            ALUout_o   <= ALUout_i;
            ImmOp_o    <= ImmOp_i;
            pcPlus4_o  <= pcPlus4_i;
            rd_o       <= rd_i;
            misalign_o <= misaligned_s;
            if (go_s && is_load_s) begin
               ReadData_o <= load_extend(funct3_i, ALUout_i[1:0], dmem_rdata_i);
            end else begin
               ReadData_o <= '0;
            end
         end else begin
            valid_o    <= 1'b0;
            RegWrite_o <= 1'b0;
            misalign_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-level memory model predicts every memory request and
// every retirement; a responder/monitor process plays the data memory and checks the DUT.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i, RegWrite_i, MemWrite_i;
   logic [1:0]  WriteSrc_i;
   logic [2:0]  funct3_i;
   logic [31:0] ALUout_i, regOp2_i, ImmOp_i, pcPlus4_i;
   logic [4:0]  rd_i;
   logic        stall_o, dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ready_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        valid_o, RegWrite_o, misalign_o;
   logic [1:0]  WriteSrc_o;
   logic [31:0] ALUout_o, ImmOp_o, pcPlus4_o, ReadData_o;
   logic [4:0]  rd_o;

   mem_stage dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
      .WriteSrc_i(WriteSrc_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
      .ALUout_i(ALUout_i), .regOp2_i(regOp2_i), .ImmOp_i(ImmOp_i), .pcPlus4_i(pcPlus4_i),
      .rd_i(rd_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
      .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .valid_o(valid_o), .RegWrite_o(RegWrite_o), .WriteSrc_o(WriteSrc_o), .ALUout_o(ALUout_o),
      .ImmOp_o(ImmOp_o), .pcPlus4_o(pcPlus4_o), .rd_o(rd_o), .ReadData_o(ReadData_o),
      .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mw, rw;
      logic [1:0]  ws;
      logic [2:0]  f3;
      logic [31:0] alu, op2, imm, pc4;
      logic [4:0]  rd;
   } ins_t;

   typedef struct {
      logic [31:0] alu, imm, pc4, rdata;
      logic [4:0]  rd;
      logic [1:0]  ws;
      logic        rw, mis;
   } ret_t;

   typedef struct {
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
   } acc_t;

   ret_t        ret_q[$];
   acc_t        acc_q[$];
   logic [7:0]  ref_mem [int];
   logic [31:0] dev_mem [int];

   int n_vec = 0;
   int n_err = 0;

   // responder controls: scripted mode gives fixed ready/rvalid timing
   bit scripted = 1'b0;
   int rdy_wait = 0;
   int rv_delay = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 8'h00;
   endfunction

   function automatic logic [31:0] dev_rd(input int wa);
      if (dev_mem.exists(wa)) return dev_mem[wa];
      return 32'h0000_0000;
   endfunction

   // Reference model: access size from funct3, memory as a plain byte array.
   task automatic predict(input ins_t in, input bit push_ret);
      ret_t        r;
      acc_t        a;
      bit          is_store, is_load, mis;
      int          size, off;
      logic [31:0] v;
      is_store = in.mw;
      is_load  = !in.mw && (in.ws == 2'b01);
      if (is_store) size = (in.f3 == 3'd0) ? 1 : (in.f3 == 3'd1) ? 2 : 4;
      else          size = (in.f3[1:0] == 2'd0) ? 1 : (in.f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(in.alu[1:0]);
      mis = (is_store || is_load) && ((int'(in.alu) % size) != 0);
      r.alu = in.alu; r.imm = in.imm; r.pc4 = in.pc4; r.rd = in.rd; r.ws = in.ws;
      r.rw = in.rw && !mis; r.mis = mis; r.rdata = 32'h0;
      if ((is_store || is_load) && !mis) begin
         a.we = is_store; a.addr = in.alu & 32'hFFFF_FFFC; a.be = 4'b1111; a.wdata = in.op2;
         if (is_store) begin
            a.be = 4'b0000;
            for (int j = 0; j < 4; j++) begin
               if (j >= off && j < off + size) a.be[j] = 1'b1;
               a.wdata[8*j +: 8] = 8'(in.op2 >> (8 * (j % size)));
            end
            for (int i = 0; i < size; i++) ref_mem[int'(in.alu) + i] = 8'(in.op2 >> (8 * i));
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_rd(int'(in.alu) + i)) << (8 * i));
            if (!in.f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            r.rdata = v;
         end
         acc_q.push_back(a);
      end
      if (push_ret) ret_q.push_back(r);
   endtask

   task automatic drive(input ins_t in);
      valid_i = 1'b1; RegWrite_i = in.rw; WriteSrc_i = in.ws; MemWrite_i = in.mw;
      funct3_i = in.f3; ALUout_i = in.alu; regOp2_i = in.op2; ImmOp_i = in.imm;
      pcPlus4_i = in.pc4; rd_i = in.rd;
   endtask

   // Issue one instruction, hold it while stalled, count stall and request cycles.
   task automatic issue(input ins_t in, output int stalls, output int reqs);
      bit done;
      predict(in, 1'b1);
      drive(in);
      stalls = 0; reqs = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (dmem_req_o) reqs++;
         if (!stall_o) done = 1'b1;
         else begin
            stalls++;
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL stall_timeout: stall_o still high after %0d cycles, required release", stalls);
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         valid_i = 1'b0; MemWrite_i = 1'($urandom); WriteSrc_i = 2'($urandom);
         funct3_i = 3'($urandom); ALUout_i = $urandom;
         @(posedge clk); #1;
      end
   endtask

   function automatic ins_t mk(input logic mw, input logic [1:0] ws, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] op2, input logic [4:0] rd);
      ins_t in;
      in.mw = mw; in.ws = ws; in.f3 = f3; in.alu = alu; in.op2 = op2; in.rd = rd;
      in.rw = !mw; in.imm = $urandom; in.pc4 = $urandom;
      return in;
   endfunction

   function automatic ins_t rand_ins();
      ins_t in;
      int   kind;
      kind = int'($urandom_range(0, 2));
      in = mk(1'b0, 2'b00, 3'($urandom), 32'($urandom_range(0, 63)), $urandom, 5'($urandom));
      in.rw = 1'($urandom);
      case (kind)
         0: begin
            case ($urandom_range(0, 2))
               0:       in.ws = 2'b00;
               1:       in.ws = 2'b10;
               default: in.ws = 2'b11;
            endcase
            in.alu = $urandom;
         end
         1: in.ws = 2'b01;
         default: in.mw = 1'b1;
      endcase
      return in;
   endfunction

   // Data-memory responder plus scoreboard monitor.
   initial begin
      int          pend;
      int          req_seen;
      logic [31:0] pend_data;
      ret_t        e;
      acc_t        x;
      pend = 0; req_seen = 0; pend_data = 32'h0;
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
      forever begin
         @(posedge clk); #1;
         dmem_rvalid_i = 1'b0;
         dmem_rdata_i  = $urandom;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               dmem_rvalid_i = 1'b1;
               dmem_rdata_i  = pend_data;
            end
         end
         dmem_ready_i = scripted ? (req_seen >= rdy_wait) : ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (valid_o) begin
            if (ret_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL retire_unexpected: got valid_o=1 rd=%0d, required no retirement", rd_o);
            end else begin
               e = ret_q.pop_front();
               chk("ret_regwrite", 32'(RegWrite_o), 32'(e.rw));
               chk("ret_misalign", 32'(misalign_o), 32'(e.mis));
               chk("ret_alu", ALUout_o, e.alu);
               chk("ret_rd", 32'(rd_o), 32'(e.rd));
               chk("ret_writesrc", 32'(WriteSrc_o), 32'(e.ws));
               chk("ret_imm", ImmOp_o, e.imm);
               chk("ret_pc4", pcPlus4_o, e.pc4);
               chk("ret_readdata", ReadData_o, e.rdata);
            end
         end
         if (dmem_req_o && dmem_ready_i) begin
            if (acc_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL req_unexpected: got request addr=0x%08h, required no request", dmem_addr_o);
            end else begin
               x = acc_q.pop_front();
               chk("req_we", 32'(dmem_we_o), 32'(x.we));
               chk("req_addr", dmem_addr_o, x.addr);
               chk("req_be", 32'(dmem_be_o), 32'(x.be));
               if (x.we) chk("req_wdata", dmem_wdata_o, x.wdata);
            end
            if (dmem_we_o) begin
               pend_data = dev_rd(int'(dmem_addr_o >> 2));
               for (int j = 0; j < 4; j++)
                  if (dmem_be_o[j]) pend_data[8*j +: 8] = dmem_wdata_o[8*j +: 8];
               dev_mem[int'(dmem_addr_o >> 2)] = pend_data;
            end else begin
               pend      = scripted ? rv_delay : int'($urandom_range(1, 3));
               pend_data = dev_rd(int'(dmem_addr_o >> 2));
            end
            req_seen = 0;
         end else if (dmem_req_o) begin
            req_seen++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t in;
      int   st, rq;
      // reset with a load presented: no request, no stall, registered outputs clear
      rst_i = 1'b1;
      in = mk(1'b0, 2'b01, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
      in.imm = 32'hDEAD_BEEF; in.pc4 = 32'hCAFE_F00D; in.alu = 32'hDEAD_BE40;
      drive(in);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_valid", 32'(valid_o), 32'h0);
         chk("rst_regwrite", 32'(RegWrite_o), 32'h0);
         chk("rst_alu", ALUout_o, 32'h0);
         chk("rst_imm", ImmOp_o, 32'h0);
         chk("rst_misalign", 32'(misalign_o), 32'h0);
         chk("rst_stall", 32'(stall_o), 32'h0);
         chk("rst_req", 32'(dmem_req_o), 32'h0);
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      valid_i = 1'b0;
      idle(2);

      scripted = 1'b1; rdy_wait = 0; rv_delay = 1;
      in = mk(1'b0, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      issue(in, st, rq);
      chk("alu_stall", 32'(st), 32'd0);
      chk("alu_req", 32'(rq), 32'd0);

      in = mk(1'b1, 2'b00, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0);
      issue(in, st, rq);
      chk("sb_stall", 32'(st), 32'd0);
      chk("sb_req", 32'(rq), 32'd1);

      dev_mem[32'h200 >> 2] = 32'h8001_0000;
      ref_mem[32'h200] = 8'h00; ref_mem[32'h201] = 8'h00;
      ref_mem[32'h202] = 8'h01; ref_mem[32'h203] = 8'h80;
      rdy_wait = 3; rv_delay = 2;
      in = mk(1'b0, 2'b01, 3'b001, 32'h0000_0202, 32'h0, 5'd7);
      issue(in, st, rq);
      chk("lh_stall", 32'(st), 32'd5);
      chk("lh_req", 32'(rq), 32'd4);
      in = mk(1'b0, 2'b01, 3'b101, 32'h0000_0202, 32'h0, 5'd8);
      issue(in, st, rq);
      chk("lhu_stall", 32'(st), 32'd5);
      chk("lhu_req", 32'(rq), 32'd4);

      rdy_wait = 0; rv_delay = 1;
      in = mk(1'b0, 2'b01, 3'b010, 32'h0000_0301, 32'h0, 5'd9);
      issue(in, st, rq);
      chk("lw_mis_stall", 32'(st), 32'd0);
      chk("lw_mis_req", 32'(rq), 32'd0);

      in = mk(1'b0, 2'b01, 3'b010, 32'h0000_0200, 32'h0, 5'd10);
      issue(in, st, rq);
      chk("b2b_lw_stall", 32'(st), 32'd1);
      in = mk(1'b0, 2'b00, 3'b000, 32'h0000_5555, 32'h0, 5'd11);
      issue(in, st, rq);
      chk("b2b_alu_stall", 32'(st), 32'd0);

      // reset while the load waits for data; its late rvalid must be ignored
      rv_delay = 6;
      in = mk(1'b0, 2'b01, 3'b010, 32'h0000_0010, 32'h0, 5'd12);
      predict(in, 1'b0);
      drive(in);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("rst_wait_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_idle_req", 32'(dmem_req_o), 32'd0);
      chk("rst_idle_stall", 32'(stall_o), 32'd0);
      chk("rst_idle_valid", 32'(valid_o), 32'd0);
      chk("rst_idle_rdata", ReadData_o, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      valid_i = 1'b0;
      idle(8);

      scripted = 1'b0;
      for (int n = 0; n < 300; n++) begin
         idle(int'($urandom_range(0, 2)));
         issue(rand_ins(), st, rq);
      end
      idle(10);
      chk("ret_queue_empty", 32'(ret_q.size()), 32'd0);
      chk("req_queue_empty", 32'(acc_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
